// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous-bus responder: one 64 KB window backed by a word RAM, DTACK after WAIT_STATES waits.
// Optional M68K_RESP_BERR_EN: out-of-range accesses terminate with BERR instead of DTACK.
module m68k_bus_responder #(
    parameter logic [7:0] BASE        = 8'h00,
    parameter int         DEPTH       = 4096,
    parameter int         WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        as,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        dtack,
    output logic        berr
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [14:0] r_idx;
    logic        r_rw;
    logic        r_uds;
    logic        r_lds;
    logic        r_in_range;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_dtack;
    logic        r_berr;
    logic [15:0] r_mem [DEPTH];

    logic        w_sel;
    logic [14:0] w_idx;
    logic        w_in_range;
    logic        w_ack_wr;
    logic        w_unused_addr;

    assign w_idx         = addr[15:1];
    assign w_sel         = (as == 1'b0) && (addr[23:16] == BASE) && ((uds == 1'b0) || (lds == 1'b0));
    assign w_in_range    = ({1'b0, w_idx} < DEPTH_W);
    assign w_ack_wr      = (r_state == S_ACK) && (r_rw == 1'b0) && r_in_range;
    assign w_unused_addr = ^{addr[31:24], addr[0]};

    assign rdata = r_rdata;
    assign dtack = r_dtack;
    assign berr  = r_berr;

    // RAM write port: byte lanes commit at the ACK edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_ack_wr) begin
            if (r_uds == 1'b0) begin
                r_mem[r_idx[AW-1:0]][15:8] <= r_wdata[15:8];
            end
            if (r_lds == 1'b0) begin
                r_mem[r_idx[AW-1:0]][7:0] <= r_wdata[7:0];
            end
        end
    end

    // Bus-cycle FSM with registered DTACK/BERR/read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= 15'd0;
            r_rw       <= 1'b1;
            r_uds      <= 1'b1;
            r_lds      <= 1'b1;
            r_in_range <= 1'b0;
            r_wdata    <= 16'h0000;
            r_rdata    <= 16'h0000;
            r_dtack    <= 1'b1;
            r_berr     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dtack <= 1'b1;
                    r_berr  <= 1'b1;
                    if (w_sel) begin
                        r_idx      <= w_idx;
                        r_rw       <= rw;
                        r_uds      <= uds;
                        r_lds      <= lds;
                        r_wdata    <= wdata;
                        r_in_range <= w_in_range;
                        r_cnt      <= WS_LOAD;
                        r_state    <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // CPU withdrew AS: drop the cycle before anything is committed
                    if (as == 1'b1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (r_rw == 1'b1) begin
                        if (r_in_range) begin
                            r_rdata <= r_mem[r_idx[AW-1:0]];
                        end else begin
`ifdef M68K_RESP_BERR_EN
                            r_rdata <= r_rdata;
`else
                            r_rdata <= 16'hFFFF;
`endif
                        end
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (as == 1'b1) begin
                        r_dtack <= 1'b1;
                        r_berr  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
`ifdef M68K_RESP_BERR_EN
                        r_dtack <= ~r_in_range;
                        r_berr  <= r_in_range;
`else
                        r_dtack <= 1'b0;
                        r_berr  <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Self-checking bench for m68k_bus_responder: directed plan steps plus randomized accesses against a word-map model.
module tb_m68k_bus_responder;

    localparam logic [7:0] BASE  = 8'h00;
    localparam int         DEPTH = 4096;
    localparam int         WS    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        as = 1'b1;
    logic        uds = 1'b1;
    logic        lds = 1'b1;
    logic        rw = 1'b1;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        dtack;
    logic        berr;

    int errors = 0;
    int checks = 0;

    // Reference model: words the bench has written, and the value rdata must hold
    logic [15:0] model_mem [int];
    logic [15:0] last_rd = 16'h0000;
    int          word_tab [16];

    m68k_bus_responder #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .as(as), .uds(uds), .lds(lds),
        .rw(rw), .wdata(wdata), .rdata(rdata), .dtack(dtack), .berr(berr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete bus cycle; expectations come from the model, never from the DUT
    task automatic bus_access(input int idx, input logic r, input logic u, input logic l,
                              input logic [15:0] wd, input int hold);
        int          lat;
        logic        inr;
        logic        exp_dtack;
        logic        exp_berr;
        logic [15:0] word;
        inr = (idx < DEPTH);
        if (r) begin
            if (inr) last_rd = model_mem[idx];
`ifndef M68K_RESP_BERR_EN
            else last_rd = 16'hFFFF;
`endif
        end else if (inr) begin
            word = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
            if (!u) word[15:8] = wd[15:8];
            if (!l) word[7:0] = wd[7:0];
            model_mem[idx] = word;
        end
`ifdef M68K_RESP_BERR_EN
        exp_dtack = !inr;
        exp_berr  = inr;
`else
        exp_dtack = 1'b0;
        exp_berr  = 1'b1;
`endif
        addr  = {8'h00, BASE, 15'(idx), 1'b0};
        rw    = r;
        uds   = u;
        lds   = l;
        wdata = wd;
        as    = 1'b0;
        lat   = -1;
        while (lat < 40) begin
            step();
            lat++;
            if (lat == 0) begin
                rw    = ~r;
                uds   = 1'($urandom);
                lds   = 1'($urandom);
                wdata = 16'($urandom);
            end
            if (dtack === 1'b0 || berr === 1'b0) break;
        end
        check("latency", 32'(lat), 32'(2 + WS));
        repeat (hold) step();
        check("dtack_term", {31'd0, dtack}, {31'd0, exp_dtack});
        check("berr_term", {31'd0, berr}, {31'd0, exp_berr});
        check("rdata", {16'd0, rdata}, {16'd0, last_rd});
        as  = 1'b1;
        uds = 1'b1;
        lds = 1'b1;
        rw  = 1'b1;
        step();
        check("dtack_release", {31'd0, dtack}, 32'd1);
        check("berr_release", {31'd0, berr}, 32'd1);
    endtask

    initial begin
        int lat;
        int k;
        int idx;
        logic r;
        logic u;
        logic l;

        // Reset state
        repeat (3) step();
        check("reset_dtack", {31'd0, dtack}, 32'd1);
        check("reset_berr", {31'd0, berr}, 32'd1);
        check("reset_rdata", {16'd0, rdata}, 32'h0000);
        rst_n = 1'b1;
        step();

        // Word write then read back
        bus_access(32'h10 >> 1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0);
        bus_access(32'h10 >> 1, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
        check("beef_read", {16'd0, rdata}, 32'hBEEF);

        // Byte lanes
        bus_access(3, 1'b0, 1'b0, 1'b1, 16'h1234, 1);
        bus_access(3, 1'b0, 1'b1, 1'b0, 16'h5678, 0);
        bus_access(3, 1'b1, 1'b0, 1'b0, 16'h0000, 2);
        check("lane_merge", {16'd0, rdata}, 32'h1278);

        // Abort during WAIT
        bus_access(32'h20 >> 1, 1'b0, 1'b0, 1'b0, 16'h1111, 0);
        addr = 32'h0000_0020; rw = 1'b0; uds = 1'b0; lds = 1'b0; wdata = 16'hAAAA; as = 1'b0;
        step();
        as = 1'b1; uds = 1'b1; lds = 1'b1; rw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort_dtack", {31'd0, dtack}, 32'd1);
        end
        bus_access(32'h20 >> 1, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
        check("abort_prior", {16'd0, rdata}, 32'h1111);

        // Unselected window
        addr = 32'h0005_0010; rw = 1'b1; uds = 1'b0; lds = 1'b0; as = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("unsel_dtack", {31'd0, dtack}, 32'd1);
            check("unsel_berr", {31'd0, berr}, 32'd1);
        end
        as = 1'b1; uds = 1'b1; lds = 1'b1;
        step();

        // Out-of-range read and write (index 5000)
        bus_access(5000, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
        bus_access(5000, 1'b0, 1'b0, 1'b0, 16'h5A5A, 0);

        // Reset pulse while in DONE
        addr = 32'h0000_0010; rw = 1'b1; uds = 1'b0; lds = 1'b0; as = 1'b0;
        lat = 0;
        while (lat < 40 && dtack !== 1'b0) begin
            step();
            lat++;
        end
        check("done_reached", {31'd0, dtack}, 32'd0);
        rst_n = 1'b0;
        as = 1'b1; uds = 1'b1; lds = 1'b1;
        #1;
        check("rst_dtack", {31'd0, dtack}, 32'd1);
        check("rst_rdata", {16'd0, rdata}, 32'h0000);
        last_rd = 16'h0000;
        #2;
        rst_n = 1'b1;
        step();
        check("idle_after_rst", {31'd0, dtack}, 32'd1);
        bus_access(32'h10 >> 1, 1'b1, 1'b1, 1'b0, 16'h0000, 0);
        check("post_rst_read", {16'd0, rdata}, 32'hBEEF);

        // Randomized accesses over a preloaded word set plus occasional out-of-range hits
        for (int i = 0; i < 16; i++) begin
            word_tab[i] = 256 + i * 37;
            bus_access(word_tab[i], 1'b0, 1'b0, 1'b0, 16'($urandom), 0);
        end
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 15));
            idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 32767)) : word_tab[k];
            r = 1'($urandom);
            u = 1'($urandom);
            l = u ? 1'b0 : 1'($urandom);
            bus_access(idx, r, u, l, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
# m68k_bus_responder

Bus-side responder for the 68000 core's asynchronous bus: decodes one address window, services word/byte reads and writes into an internal word RAM, and terminates each cycle with DTACK after a programmable number of wait states. Sits on the CPU side of the top level, alongside the 68000 core, and drives the core's DTACK and read-data inputs. It is the responding end of the cycle the CPU initiates with AS/UDS/LDS/RW.

## Interface

Parameters:
- BASE, 8'h00: value of addr[23:16] that selects this responder (64 KB window).
- DEPTH, 4096: RAM size in 16-bit words (power of two, ≤ 32768).
- WAIT_STATES, 2: wait cycles inserted before DTACK (0–15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  CPU byte address; only [23:1] used.
- as  in  1  address strobe, active-low.
- uds  in  1  upper data strobe, active-low, lane [15:8].
- lds  in  1  lower data strobe, active-low, lane [7:0].
- rw  in  1  1 = read, 0 = write.
- wdata  in  16  write data from CPU.
- rdata  out  16  read data to CPU.
- dtack  out  1  data acknowledge, active-low.
- berr  out  1  bus error, active-low (held high unless M68K_RESP_BERR_EN).

## Operation

- Select: as low, addr[23:16] == BASE, at least one of uds/lds low. Unselected cycles are ignored (dtack stays high; other responders own them).
- Word index = addr[15:1]; in range when index < DEPTH.
- FSM states: IDLE, WAIT, ACK, DONE.
  - IDLE: on select, latch index, rw, uds, lds, wdata; go WAIT (or ACK if WAIT_STATES = 0); load wait counter with WAIT_STATES−1.
  - WAIT: decrement counter; at 0 go ACK. If as goes high, abort to IDLE: no write, no dtack.
  - ACK: one cycle; performs write (only lanes whose latched strobe is low) or latches RAM word into rdata; go DONE.
  - DONE: dtack low; hold rdata; when as sampled high, dtack high, go IDLE.
- Out-of-range index (no macro): reads return 16'hFFFF, writes discarded, dtack handshake unchanged.
- rdata holds last read value outside read cycles; 16'h0000 after reset.
- rw/strobe changes after latching are ignored until the next cycle.
- RAM contents are not reset.

## Timing

- Edge 0: select sampled in IDLE. ACK occupies edge 1+WAIT_STATES; dtack falls and rdata valid at edge 2+WAIT_STATES.
- Write commits at the ACK edge; a read at the next cycle sees it.
- dtack rises on the first edge at which as is sampled high in DONE; back-to-back cycle may be selected on the following edge.
- Reset (any time, including mid-cycle): state IDLE, dtack = 1, berr = 1, rdata = 16'h0000, counter 0; an in-flight write not yet at ACK is dropped.

## Configuration

- M68K_RESP_BERR_EN defined: an out-of-range access drives berr low instead of dtack in DONE (same timing), no RAM write, rdata unchanged; berr releases when as goes high.
- Undefined: berr tied high; out-of-range behaves as described in Operation.

## Test plan

- WAIT_STATES=2: word write 16'hBEEF to 0x000010, then read -> dtack low at edge 4 after as sampled, rdata = 16'hBEEF.
- Byte lanes: write 16'h1234 with uds only, then 16'h5678 with lds only to same word -> read returns 16'h1278.
- Abort: as deasserted during WAIT of a write of 16'hAAAA -> dtack never falls, subsequent read returns prior contents.
- Unselected: addr[23:16] ≠ BASE with as low for 20 cycles -> dtack and berr stay high.
- Out of range (DEPTH=4096, index 5000): read -> rdata 16'hFFFF with dtack; with M68K_RESP_BERR_EN -> berr low, dtack high.
- rst_n pulsed low in DONE -> dtack returns high immediately, FSM IDLE, next access completes normally.
